dmem_lsu: RTL and testbench

//  Data-memory stage target: the block the pipeline's M stage drives via address_dmem/data/wren/access_type.
//  It holds the word-organised data RAM and applies byte/half/word store lane enables.
//  It performs load lane selection with sign/zero extension, so q is register-ready when captured into MW.
//  It also decodes a small MMIO window: a free-running cycle counter, GPIO out and GPIO in.

---
 rtl/dmem_lsu.sv | 164 ++++++++++++++++
 tb/tb_dmem_lsu.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_lsu
//  Purpose  : Data-memory stage. Word-organised RAM with B/H/W store byte
//             enables, combinational load lane select with sign/zero extend,
//             and a 3-word MMIO window (cycle counter, gpio_out, gpio_in).
//  Options  : DMEM_MISALIGN_TRAP_EN - suppress misaligned H/W accesses and
//             flag them on misalign_err (tied 0 when undefined).
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] MMIO_BASE_W = 32'h0000_4000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [1:0]  byte_off,
    input  logic [31:0] data,
    input  logic        wren,
    input  logic [2:0]  access_type,
    output logic [31:0] q,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic        misalign_err
);

    localparam int          c_DEPTH    = 1 << ADDR_W;
    localparam logic [31:0] c_MMIO_CYC = MMIO_BASE_W;
    localparam logic [31:0] c_MMIO_GPO = MMIO_BASE_W + 32'd1;
    localparam logic [31:0] c_MMIO_GPI = MMIO_BASE_W + 32'd2;

    logic [31:0]       r_mem [c_DEPTH];
    logic [31:0]       r_cycle;
    logic [31:0]       r_gpio_out;
    logic [31:0]       r_gpio_in;

    logic              w_sel_ram;
    logic              w_sel_cyc;
    logic              w_sel_gpo;
    logic              w_sel_gpi;
    logic [ADDR_W-1:0] w_idx;
    logic              w_ld_half;
    logic              w_ld_word;
    logic              w_ld_signed;
    logic              w_misalign;
    logic              w_wr_ok;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rd_word;
    logic [7:0]        w_rd_byte;
    logic [15:0]       w_rd_half;

    // Region decode: everything below the MMIO window is RAM (upper bits alias)
    assign w_sel_ram = (address < MMIO_BASE_W);
    assign w_sel_cyc = (address == c_MMIO_CYC);
    assign w_sel_gpo = (address == c_MMIO_GPO);
    assign w_sel_gpi = (address == c_MMIO_GPI);
    assign w_idx     = address[ADDR_W-1:0];

    // Access width from funct3: x00 byte, x01 half, x1x word
    assign w_ld_half   = (access_type[1:0] == 2'b01);
    assign w_ld_word   = access_type[1];
    assign w_ld_signed = ~access_type[2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = (w_ld_half & byte_off[0]) | (w_ld_word & (byte_off != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_wr_ok = wren & ~reset & ~w_misalign;

    // Store lane enables and lane-replicated write data
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = data;
        case (access_type)
            3'b000: begin
                w_be    = 4'b0001 << byte_off;
                w_wdata = {4{data[7:0]}};
            end
            3'b001: begin
                w_be    = byte_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = data;
            end
        endcase
    end

    // RAM write with byte enables; contents survive reset
    always_ff @(posedge clock) begin
        if (w_wr_ok && w_sel_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    // MMIO registers: cycle counter, gpio_out (byte-enabled), gpio_in sample
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle    <= 32'h0;
            r_gpio_out <= 32'h0;
            r_gpio_in  <= 32'h0;
        end else begin
            r_cycle   <= r_cycle + 32'd1;
            r_gpio_in <= gpio_in;
            if (w_wr_ok && w_sel_gpo) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be[i]) r_gpio_out[8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Source word for the load; unmapped MMIO space reads as zero
    always_comb begin
        w_rd_word = 32'h0;
        if (w_sel_ram)      w_rd_word = r_mem[w_idx];
        else if (w_sel_cyc) w_rd_word = r_cycle;
        else if (w_sel_gpo) w_rd_word = r_gpio_out;
        else if (w_sel_gpi) w_rd_word = r_gpio_in;
    end

    // Lane select and extension; old word is seen during a same-word store
    always_comb begin
        w_rd_byte = 8'h0;
        case (byte_off)
            2'd0:    w_rd_byte = w_rd_word[7:0];
            2'd1:    w_rd_byte = w_rd_word[15:8];
            2'd2:    w_rd_byte = w_rd_word[23:16];
            default: w_rd_byte = w_rd_word[31:24];
        endcase
        w_rd_half = byte_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        q = 32'h0;
        if (!reset && !w_misalign) begin
            if (w_ld_word)      q = w_rd_word;
            else if (w_ld_half) q = {{16{w_ld_signed & w_rd_half[15]}}, w_rd_half};
            else                q = {{24{w_ld_signed & w_rd_byte[7]}}, w_rd_byte};
        end
    end

    assign gpio_out = r_gpio_out;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic r_misalign_err;

    // One-cycle-late flag for every cycle that presented a misaligned access
    always_ff @(posedge clock) begin
        if (reset) r_misalign_err <= 1'b0;
        else       r_misalign_err <= w_misalign;
    end

    assign misalign_err = r_misalign_err;
`else
    assign misalign_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_lsu
//  Purpose  : Self-checking bench for dmem_lsu: word-level memory model plus
//             directed vectors with literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_4000;
    localparam logic [2:0]  F_B = 3'b000, F_H = 3'b001, F_W = 3'b010;
    localparam logic [2:0]  F_BU = 3'b100, F_HU = 3'b101;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [1:0]  byte_off;
    logic [31:0] data;
    logic        wren;
    logic [2:0]  access_type;
    logic [31:0] q;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        misalign_err;

    dmem_lsu #(.ADDR_W(10), .MMIO_BASE_W(BASE)) dut (
        .clock(clock), .reset(reset), .address(address), .byte_off(byte_off),
        .data(data), .wren(wren), .access_type(access_type), .q(q),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .misalign_err(misalign_err)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [int];
    logic [31:0] m_cyc, m_gpo, m_gsamp;
    logic        m_merr;
    logic [32:0] cmp_e;

    function automatic bit m_mis(input logic [2:0] f, input logic [1:0] o);
        bit half_bad, word_bad;
        half_bad = (f == 3'b001 || f == 3'b101) && o[0];
        word_bad = (f == 3'b010 || f == 3'b011 || f == 3'b110 || f == 3'b111) && (o != 2'b00);
        return TRAP && (half_bad || word_bad);
    endfunction

    // {known, value} of the expected load result for the current inputs
    function automatic logic [32:0] m_read();
        logic [31:0] w;
        logic [31:0] lane;
        int          idx;
        if (reset) return {1'b1, 32'h0};
        if (address < BASE) begin
            idx = int'(address % DEPTH);
            if (!m_mem.exists(idx)) return {1'b0, 32'h0};
            w = m_mem[idx];
        end else if (address == BASE)         w = m_cyc;
        else if (address == BASE + 32'd1)     w = m_gpo;
        else if (address == BASE + 32'd2)     w = m_gsamp;
        else                                  w = 32'h0;
        if (m_mis(access_type, byte_off)) return {1'b1, 32'h0};
        case (access_type)
            3'b000, 3'b100: begin
                lane = (w >> (8 * int'(byte_off))) & 32'hFF;
                if (access_type == 3'b000 && lane[7]) lane = lane | 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                lane = (w >> (16 * int'(byte_off[1]))) & 32'hFFFF;
                if (access_type == 3'b001 && lane[15]) lane = lane | 32'hFFFF_0000;
            end
            default: lane = w;
        endcase
        return {1'b1, lane};
    endfunction

    task automatic m_store();
        logic [31:0] mask, val;
        int          sh, idx;
        case (access_type)
            3'b000: begin sh = 8 * int'(byte_off);     mask = 32'hFF << sh;   val = data << sh; end
            3'b001: begin sh = 16 * int'(byte_off[1]); mask = 32'hFFFF << sh; val = data << sh; end
            default: begin mask = 32'hFFFF_FFFF; val = data; end
        endcase
        if (address < BASE) begin
            idx = int'(address % DEPTH);
            if (m_mem.exists(idx))          m_mem[idx] = (m_mem[idx] & ~mask) | (val & mask);
            else if (mask == 32'hFFFF_FFFF) m_mem[idx] = val;
        end else if (address == BASE + 32'd1) begin
            m_gpo = (m_gpo & ~mask) | (val & mask);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_cyc = 0; m_gpo = 0; m_gsamp = 0; m_merr = 0;
        end else begin
            if (wren && !m_mis(access_type, byte_off)) m_store();
            m_cyc   = m_cyc + 32'd1;
            m_gsamp = gpio_in;
            m_merr  = m_mis(access_type, byte_off);
        end
    endtask

    // Model advances on each active edge from the inputs presented that cycle
    always @(posedge clock) model_edge();

    // Compare DUT against the model away from the active edge
    always @(negedge clock) begin
        if (chk_en) begin
            cmp_e = m_read();
            if (cmp_e[32]) check("model_q", q, cmp_e[31:0]);
            check("model_gpio_out", gpio_out, m_gpo);
            check("model_misalign_err", {31'b0, misalign_err}, {31'b0, m_merr});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic acc(input logic [31:0] a, input logic [1:0] o, input logic [31:0] d,
                       input logic w, input logic [2:0] f);
        address = a; byte_off = o; data = d; wren = w; access_type = f;
    endtask

    task automatic st(input logic [31:0] a, input logic [1:0] o, input logic [31:0] d,
                      input logic [2:0] f);
        acc(a, o, d, 1'b1, f);
        step();
        wren = 1'b0;
    endtask

    task automatic ld(input string name, input logic [31:0] a, input logic [1:0] o,
                      input logic [2:0] f, input logic [31:0] exp);
        acc(a, o, 32'h0, 1'b0, f);
        @(negedge clock);
        check(name, q, exp);
        step();
    endtask

    initial begin
        reset = 1'b1; gpio_in = 32'h0;
        acc(32'h0, 2'd0, 32'h0, 1'b0, F_W);
        step();
        chk_en = 1'b1;
        @(negedge clock);
        check("reset_q", q, 32'h0);
        check("reset_gpio_out", gpio_out, 32'h0);
        check("reset_misalign", {31'b0, misalign_err}, 32'h0);
        step();
        reset = 1'b0;

        // Load lane select and extension
        st(32'd5, 2'd0, 32'h8081_7F80, F_W);
        ld("lb_off0",  32'd5, 2'd0, F_B,  32'hFFFF_FF80);
        ld("lbu_off0", 32'd5, 2'd0, F_BU, 32'h0000_0080);
        ld("lb_off1",  32'd5, 2'd1, F_B,  32'h0000_007F);
        ld("lh_off2",  32'd5, 2'd2, F_H,  32'hFFFF_8081);
        ld("lhu_off2", 32'd5, 2'd2, F_HU, 32'h0000_8081);

        // Partial stores merge into the word
        st(32'd7, 2'd0, 32'h1122_3344, F_W);
        st(32'd7, 2'd2, 32'h0000_00AA, F_B);
        st(32'd7, 2'd0, 32'h0000_BEEF, F_H);
        ld("merge_w7", 32'd7, 2'd0, F_W, 32'h11AA_BEEF);

        // Read during write of the same word
        st(32'd3, 2'd0, 32'h0102_0304, F_W);
        acc(32'd3, 2'd0, 32'hDEAD_BEEF, 1'b1, F_W);
        @(negedge clock);
        check("rdw_old", q, 32'h0102_0304);
        step();
        wren = 1'b0;
        @(negedge clock);
        check("rdw_new", q, 32'hDEAD_BEEF);
        step();

        // Cycle counter after a 1-cycle reset
        reset = 1'b1;
        acc(BASE, 2'd0, 32'h0, 1'b0, F_W);
        @(negedge clock);
        check("reset_q_mmio", q, 32'h0);
        step();
        reset = 1'b0;
        repeat (10) step();
        @(negedge clock);
        check("cycle_10", q, 32'd10);
        step();

        // gpio_out write, gpio_in sample latency
        st(BASE + 32'd1, 2'd0, 32'h0000_0055, F_W);
        @(negedge clock);
        check("gpio_out_55", gpio_out, 32'h0000_0055);
        step();
        acc(BASE + 32'd2, 2'd0, 32'h0, 1'b0, F_W);
        gpio_in = 32'h0000_00A5;
        @(negedge clock);
        check("gpio_in_first", q, 32'h0);
        step();
        @(negedge clock);
        check("gpio_in_second", q, 32'h0000_00A5);
        step();

        // Byte store into gpio_out lane 3, writes to read-only / unmapped MMIO
        st(BASE + 32'd1, 2'd3, 32'h0000_00C3, F_B);
        @(negedge clock);
        check("gpio_out_b3", gpio_out, 32'hC300_0055);
        step();
        st(BASE, 2'd0, 32'h0000_FFFF, F_W);
        st(BASE + 32'd3, 2'd0, 32'h1234_5678, F_W);
        ld("mmio_plus3", BASE + 32'd3, 2'd0, F_W, 32'h0);
        ld("mmio_far",   32'hFFFF_FFFF, 2'd0, F_W, 32'h0);

        // Aliasing and reset-discarded store
        st(32'd1028, 2'd0, 32'hCAFE_F00D, F_W);
        ld("alias_4", 32'd4, 2'd0, F_W, 32'hCAFE_F00D);
        reset = 1'b1;
        acc(32'd4, 2'd0, 32'h1234_5678, 1'b1, F_W);
        @(negedge clock);
        check("reset_mid_q", q, 32'h0);
        step();
        reset = 1'b0; wren = 1'b0;
        ld("reset_store_drop", 32'd4, 2'd0, F_W, 32'hCAFE_F00D);

        // Misaligned word store
        st(32'd9, 2'd0, 32'h0, F_W);
        st(32'd9, 2'd1, 32'h0000_1234, F_W);
        acc(32'd9, 2'd0, 32'h0, 1'b0, F_W);
        @(negedge clock);
        if (TRAP) begin
            check("mis_word_unchanged", q, 32'h0);
            check("mis_err_high", {31'b0, misalign_err}, 32'h1);
        end else begin
            check("nomis_word_written", q, 32'h0000_1234);
            check("nomis_err_low", {31'b0, misalign_err}, 32'h0);
        end
        step();
        @(negedge clock);
        check("mis_err_clear", {31'b0, misalign_err}, 32'h0);
        step();

        // Sweep all funct3 x offset loads of word 5; model does the checking
        for (int f = 0; f < 8; f++) begin
            for (int o = 0; o < 4; o++) begin
                acc(32'd5, 2'(o), 32'h0, 1'b0, 3'(f));
                step();
            end
        end
        acc(32'd5, 2'd0, 32'h0, 1'b0, F_W);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish within 20000 cycles");
        $fatal(1);
    end

endmodule
`default_nettype wire
